sigdel_decim: RTL and testbench
===============================

// Module: sigdel_decim
// PURPOSE
//  Digital half of the first-order sigma-delta ADC.
//  - Samples the external comparator and drives the 1-bit feedback DAC pin.
//  - Decimates the bitstream by counting ones over a fixed window (accumulate-and-dump).
//  - Produces the 12-bit sample consumed by the serial ASCII-hex transmitter.
//  - The output word is held stable for a whole window, so a transmit frame never sees it change mid-character.
// PARAMETERS
//  DECIM_LOG2   12  log2 of the window length in ena ticks (window = 2**DECIM_LOG2 ticks)
//  WIDTH        12  width of the data output
//  SYNC_STAGES   2  flops in the cmp_in synchronizer (>=2)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      reset: synchronous, active-low
//  ena        in   1      modulator sample tick, 1-clk pulse
//  cmp_in     in   1      asynchronous comparator output, 1 = input above feedback level
//  fb_out     out  1      feedback DAC drive, registered
//  data       out  WIDTH  last completed decimated sample
//  data_vld   out  1      1-clk strobe in the cycle data updates
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - fb_out=0, data=0, data_vld=0.
//   - Accumulator=0, window counter=0, all synchronizer flops=0.
//   - Reset mid-window discards the partial count; the next window starts at the first ena after release.
//  Synchronizer:
//   - cmp_in passes through SYNC_STAGES flops every clk, regardless of ena.
//   - cmp_s is the last stage.
//  Sampling (clk cycle with ena=1):
//   - fb_out <= cmp_s.
//   - acc <= acc + cmp_s.
//   - wcnt <= wcnt + 1 (DECIM_LOG2 bits, wraps to 0).
//   - acc is DECIM_LOG2+1 bits, so it holds a full count of 2**DECIM_LOG2 without wrap.
//  ena=0: fb_out, acc, wcnt and data hold; data_vld=0.
//  Window end (ena=1 and wcnt == 2**DECIM_LOG2-1):
//   - cnt = acc + cmp_s, which includes the current bit.
//   - sat = min(cnt, 2**DECIM_LOG2-1), so a full window of ones saturates and never wraps to 0.
//   - data <= sat scaled to WIDTH:
//     - DECIM_LOG2 >= WIDTH: top WIDTH bits of sat.
//     - DECIM_LOG2 < WIDTH: sat << (WIDTH-DECIM_LOG2).
//   - acc <= 0 in the same cycle, so no sample is lost or counted twice across windows.
//   - data_vld <= 1 for exactly one clk.
//  Timing:
//   - data and data_vld change on the clk after the last ena of the window.
//   - data is otherwise constant.
//   - Latency cmp_in -> fb_out: SYNC_STAGES clks + wait to next ena + 1 clk.
//  Default result: cnt/4096 full scale; ideal mid-scale (50% density) gives 0x800.
//  ena is assumed to be at most one pulse per clk; back-to-back ena on every clk is legal.
// TESTING
//  1. cmp_in=1 constant, 4096 ena ticks -> data=0xFFF (saturated), data_vld high 1 clk, fb_out=1.
//  2. cmp_in=0 constant, 4096 ticks -> data=0x000, data_vld pulses once; fb_out=0.
//  3. cmp_in toggles each ena (50% density) -> data=0x800; a second window also gives 0x800.
//  4. Exactly 1000 ones then zeros in a window, ena with random 0-5 clk gaps -> data=0x3E8.
//     data_vld count equals the window count.
//  5. Reset held 1 clk after 2000 ticks of ones, then all ones -> data stays 0 until 4096 post-reset ticks.
//     Then data=0xFFF.
//  6. cmp_in 0->1 step, ena every clk -> fb_out rises exactly SYNC_STAGES+1 clks later.
//     With ena=0 throughout, fb_out, data and data_vld never change.

Source files
------------

// File: rtl/sigdel_decim.sv
// Digital half of a first-order sigma-delta ADC.
// Synchronizes the comparator, drives the 1-bit feedback DAC and decimates the
// bitstream by counting ones over a window of 2**DECIM_LOG2 ena ticks.
// The result is held stable for a whole window and announced with a 1-clk strobe.
module sigdel_decim #(
    parameter int DECIM_LOG2  = 12,
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmp_in,
    output logic             fb_out,
    output logic [WIDTH-1:0] data,
    output logic             data_vld
);

    localparam logic [DECIM_LOG2-1:0] WCNT_LAST = '1;
    localparam logic [DECIM_LOG2:0]   SAT_MAX   = {1'b0, {DECIM_LOG2{1'b1}}};

    // Synchronizer chain; stage 0 takes the raw comparator, later stages shift.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   cmp_s;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = cmp_in;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign cmp_s = sync_reg[SYNC_STAGES-1];

    // Synchronizer flops advance every clock, independent of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    // Decimator state. acc has one extra bit so a full window of ones fits.
    logic [DECIM_LOG2:0]   acc_reg;
    logic [DECIM_LOG2-1:0] wcnt_reg;
    logic                  fb_reg;
    logic [WIDTH-1:0]      data_reg;
    logic                  data_vld_reg;

    // Count including the bit being sampled now; this is the window total
    // on the last tick, which is why the dump uses it instead of acc_reg.
    logic [DECIM_LOG2:0]   cnt_next;
    logic [DECIM_LOG2-1:0] sat;
    logic [WIDTH-1:0]      scaled;

    assign cnt_next = acc_reg + {{DECIM_LOG2{1'b0}}, cmp_s};
    // A full window of ones would be 2**DECIM_LOG2; clamp so it reads as
    // full scale instead of wrapping to zero.
    assign sat      = (cnt_next > SAT_MAX) ? SAT_MAX[DECIM_LOG2-1:0]
                                           : cnt_next[DECIM_LOG2-1:0];

    generate
        if (DECIM_LOG2 >= WIDTH) begin : g_scale_down
            assign scaled = sat[DECIM_LOG2-1 -: WIDTH];
        end else begin : g_scale_up
            assign scaled = {sat, {(WIDTH-DECIM_LOG2){1'b0}}};
        end
    endgenerate

    // Sample on ena; at window end dump the count and restart accumulation
    // in the same cycle so no tick is lost or double counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            wcnt_reg     <= '0;
            fb_reg       <= 1'b0;
            data_reg     <= '0;
            data_vld_reg <= 1'b0;
        end else begin
            data_vld_reg <= 1'b0;
            if (ena) begin
                fb_reg   <= cmp_s;
                wcnt_reg <= wcnt_reg + 1'b1;
                if (wcnt_reg == WCNT_LAST) begin
                    acc_reg      <= '0;
                    data_reg     <= scaled;
                    data_vld_reg <= 1'b1;
                end else begin
                    acc_reg <= cnt_next;
                end
            end
        end
    end

    assign fb_out   = fb_reg;
    assign data     = data_reg;
    assign data_vld = data_vld_reg;

endmodule

// File: tb/tb_sigdel_decim.sv
// Self-checking bench for sigdel_decim: per-cycle comparison against a
// window-counting reference model, a table of pattern vectors, and
// hand-written sequences for reset, latency and hold behaviour.
module tb_sigdel_decim;

    localparam int DECIM_LOG2  = 12;
    localparam int WIDTH       = 12;
    localparam int SYNC_STAGES = 2;
    localparam int WINDOW      = 1 << DECIM_LOG2;
    localparam int MAXC        = WINDOW - 1;

    localparam int P_ONES      = 0;
    localparam int P_ZEROS     = 1;
    localparam int P_TOGGLE    = 2;
    localparam int P_FIRST1000 = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             cmp_in = 1'b0;
    logic             fb_out;
    logic [WIDTH-1:0] data;
    logic             data_vld;

    sigdel_decim #(
        .DECIM_LOG2 (DECIM_LOG2),
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .cmp_in  (cmp_in),
        .fb_out  (fb_out),
        .data    (data),
        .data_vld(data_vld)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the comparator value seen by the modulator is the
    // input from SYNC_STAGES clocks earlier; ones are counted per window.
    bit hist[$];
    int m_ones  = 0;
    int m_ticks = 0;
    int m_data  = 0;
    bit m_fb    = 1'b0;
    bit m_vld   = 1'b0;
    int dut_vld_count = 0;

    typedef struct {
        int pat;
        bit gaps;
        int nwin;
        int exp_data;
        bit exp_fb;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int scale(input int c);
        int s;
        s = (c > MAXC) ? MAXC : c;
        if (DECIM_LOG2 >= WIDTH) return s >> (DECIM_LOG2 - WIDTH);
        else return s << (WIDTH - DECIM_LOG2);
    endfunction

    function automatic bit pat_bit(input int p, input int i);
        case (p)
            P_ONES:      return 1'b1;
            P_ZEROS:     return 1'b0;
            P_TOGGLE:    return 1'((i & 1) != 0);
            P_FIRST1000: return 1'(i < 1000);
            default:     return 1'b0;
        endcase
    endfunction

    // One clock: drive inputs, advance the model on the edge, compare at +1.
    task automatic step(input bit r, input bit e, input bit c);
        bit b;
        rst_n  = r;
        ena    = e;
        cmp_in = c;
        @(posedge clk);
        if (!r) begin
            hist.delete();
            for (int k = 0; k < SYNC_STAGES; k++) hist.push_back(1'b0);
            m_ones  = 0;
            m_ticks = 0;
            m_fb    = 1'b0;
            m_data  = 0;
            m_vld   = 1'b0;
        end else begin
            b = hist.pop_front();
            hist.push_back(c);
            m_vld = 1'b0;
            if (e) begin
                m_fb = b;
                m_ones += int'(b);
                m_ticks++;
                if (m_ticks == WINDOW) begin
                    m_data  = scale(m_ones);
                    m_vld   = 1'b1;
                    m_ones  = 0;
                    m_ticks = 0;
                end
            end
        end
        #1;
        if (data_vld) dut_vld_count++;
        check("fb_out", int'(fb_out), int'(m_fb));
        check("data", int'(data), m_data);
        check("data_vld", int'(data_vld), int'(m_vld));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int lat;
        int wins;
        int cyc;
        int p;

        vecs[0] = '{pat: P_ONES,      gaps: 1'b0, nwin: 1, exp_data: 'hFFF, exp_fb: 1'b1};
        vecs[1] = '{pat: P_ZEROS,     gaps: 1'b0, nwin: 1, exp_data: 'h000, exp_fb: 1'b0};
        vecs[2] = '{pat: P_TOGGLE,    gaps: 1'b0, nwin: 2, exp_data: 'h800, exp_fb: 1'b1};
        vecs[3] = '{pat: P_FIRST1000, gaps: 1'b1, nwin: 1, exp_data: 'h3E8, exp_fb: 1'b0};

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check("reset data", int'(data), 0);
        check("reset fb_out", int'(fb_out), 0);
        check("reset data_vld", int'(data_vld), 0);

        // Table-driven pattern windows
        for (int v = 0; v < 4; v++) begin
            p = vecs[v].pat;
            dut_vld_count = 0;
            step(1'b1, 1'b0, pat_bit(p, -2));
            step(1'b1, 1'b0, pat_bit(p, -1));
            for (int i = 0; i < vecs[v].nwin * WINDOW; i++) begin
                gap = vecs[v].gaps ? int'($urandom_range(0, 5)) : 0;
                // Let a level change settle through the synchronizer so the
                // intended bit is the one sampled.
                if (vecs[v].gaps && pat_bit(p, i) != pat_bit(p, i - 1) && gap < SYNC_STAGES)
                    gap = SYNC_STAGES;
                repeat (gap) step(1'b1, 1'b0, pat_bit(p, i));
                step(1'b1, 1'b1, pat_bit(p, i));
            end
            check($sformatf("vec%0d data", v), int'(data), vecs[v].exp_data);
            check($sformatf("vec%0d vld count", v), dut_vld_count, vecs[v].nwin);
            check($sformatf("vec%0d fb_out", v), int'(fb_out), int'(vecs[v].exp_fb));
            $display("vector %0d: pattern %0d, %0d windows, data=0x%0h", v, p, vecs[v].nwin, data);
        end

        // Reset in the middle of a window discards the partial count
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("mid-window reset data", int'(data), 0);
        for (int k = 0; k < SYNC_STAGES; k++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < WINDOW; i++) begin
            step(1'b1, 1'b1, 1'b1);
            if (i == WINDOW - 2) check("data held before window end", int'(data), 0);
        end
        check("post-reset window data", int'(data), 'hFFF);
        check("post-reset window vld", int'(data_vld), 1);
        $display("reset sequence: data=0x%0h after %0d post-reset ticks", data, WINDOW);

        // Step response latency with ena every clock
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        lat = 0;
        do begin
            step(1'b1, 1'b1, 1'b1);
            lat++;
        end while (fb_out == 1'b0 && lat < 20);
        check("fb_out step latency", lat, SYNC_STAGES + 1);
        $display("latency sequence: fb_out rose after %0d clocks", lat);

        // ena held low: outputs must not move whatever cmp_in does
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        check("hold fb_out", int'(fb_out), 1);
        check("hold data", int'(data), 'hFFF);
        check("hold data_vld", int'(data_vld), 0);
        $display("hold sequence: 50 clocks with ena low");

        // Random bitstream and random ena density against the model
        dut_vld_count = 0;
        wins = 0;
        cyc  = 0;
        while (wins < 2 && cyc < 30000) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (m_vld) begin
                wins++;
                $display("random window %0d: data=0x%0h", wins, data);
            end
            cyc++;
        end
        check("random windows completed", wins, 2);
        check("random vld count", dut_vld_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
